// File: rtl/bus_demux.sv
// Write-side demultiplexer: buffers {select, data} words from the result bus in a
// small FIFO and delivers them in order to destination ports A, B or C.
module bus_demux #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_select,
  input  logic [WIDTH-1:0]     in_data,

  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     a_data,
  output logic [CNT_WIDTH-1:0] a_count,

  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [WIDTH-1:0]     b_data,
  output logic [CNT_WIDTH-1:0] b_count,

  output logic                 c_valid,
  input  logic                 c_ready,
  output logic [WIDTH-1:0]     c_data,
  output logic [CNT_WIDTH-1:0] c_count,

  output logic                 busy
);

  localparam int PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OccWidth = $clog2(DEPTH + 1);
  localparam logic [OccWidth-1:0] FullCount = OccWidth'(DEPTH);

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // Valid and data are held stable until accepted; no valid depends on a ready.

  logic [1:0]          selMem  [DEPTH];
  logic [WIDTH-1:0]    dataMem [DEPTH];
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic [OccWidth-1:0] occupancy;

  logic                notEmpty;
  logic [1:0]          headSel;
  logic [WIDTH-1:0]    headData;
  logic                headA;
  logic                headB;
  logic                headC;
  logic                popA;
  logic                popB;
  logic                popC;
  logic                doPush;
  logic                doPop;

  assign notEmpty = (occupancy != '0);
  assign headSel  = selMem[rdPtr];
  assign headData = dataMem[rdPtr];

  // Select 3 is an alias for destination A.
  assign headA = notEmpty && ((headSel == 2'd0) || (headSel == 2'd3));
  assign headB = notEmpty && (headSel == 2'd1);
  assign headC = notEmpty && (headSel == 2'd2);

  assign a_valid = headA;
  assign b_valid = headB;
  assign c_valid = headC;

  assign a_data = headA ? headData : '0;
  assign b_data = headB ? headData : '0;
  assign c_data = headC ? headData : '0;

  assign popA  = headA && a_ready;
  assign popB  = headB && b_ready;
  assign popC  = headC && c_ready;
  assign doPop = popA || popB || popC;

  // Full blocks a push even when the head pops in the same cycle.
  assign in_ready = (occupancy != FullCount) && !reset;
  assign doPush   = in_valid && in_ready;

  assign busy = notEmpty;

  // Storage needs no reset: nothing is read out unless occupancy says so.
  always_ff @(posedge clk) begin
    if (doPush) begin
      selMem[wrPtr]  <= in_select;
      dataMem[wrPtr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Transfer counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_count <= '0;
      b_count <= '0;
      c_count <= '0;
    end else begin
      if (popA) begin
        a_count <= a_count + 1'b1;
      end
      if (popB) begin
        b_count <= b_count + 1'b1;
      end
      if (popC) begin
        c_count <= c_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_demux.sv
// Self-checking bench for bus_demux: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the delivery rules.
module tb_bus_demux;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 2;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_select;
  logic [WIDTH-1:0]     in_data;
  logic                 a_valid, b_valid, c_valid;
  logic                 a_ready, b_ready, c_ready;
  logic [WIDTH-1:0]     a_data, b_data, c_data;
  logic [CNT_WIDTH-1:0] a_count, b_count, c_count;
  logic                 busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bus_demux #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_select(in_select),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_count  (a_count),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_count  (b_count),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_data   (c_data),
    .c_count  (c_count),
    .busy     (busy)
  );

  // ---------------- scoreboard / model ----------------
  logic [WIDTH+1:0]     exp_q[$];     // {select, data} words still owed to a port
  logic [CNT_WIDTH-1:0] modelCnt[3];  // index 0=A, 1=B, 2=C
  int vecCount  = 0;
  int missCount = 0;

  function automatic int destOf(input logic [1:0] sel);
    if (sel == 2'd1) return 1;
    if (sel == 2'd2) return 2;
    return 0;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    foreach (modelCnt[i]) modelCnt[i] = '0;
  endtask

  task automatic checkOutputs();
    logic [2:0]       v;
    logic [WIDTH-1:0] hd;
    v  = '0;
    hd = '0;
    if (exp_q.size() != 0) begin
      v[destOf(exp_q[0][WIDTH+1:WIDTH])] = 1'b1;
      hd = exp_q[0][WIDTH-1:0];
    end
    checkVal("a_valid", a_valid, v[0]);
    checkVal("b_valid", b_valid, v[1]);
    checkVal("c_valid", c_valid, v[2]);
    checkVal("a_data", a_data, v[0] ? hd : '0);
    checkVal("b_data", b_data, v[1] ? hd : '0);
    checkVal("c_data", c_data, v[2] ? hd : '0);
    checkVal("in_ready", in_ready, exp_q.size() < DEPTH);
    checkVal("busy", busy, exp_q.size() != 0);
    checkVal("a_count", a_count, modelCnt[0]);
    checkVal("b_count", b_count, modelCnt[1]);
    checkVal("c_count", c_count, modelCnt[2]);
  endtask

  // ---------------- driver ----------------
  // Entered 1ns after a rising edge; drives, checks, advances one cycle.
  task automatic step(input logic iv, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                      input logic ar, input logic br, input logic cr);
    logic [2:0] rdy;
    bit         doPush;
    bit         doPop;
    int         dst;
    in_valid  = iv;
    in_select = sel;
    in_data   = d;
    a_ready   = ar;
    b_ready   = br;
    c_ready   = cr;
    #1;
    checkOutputs();
    rdy    = {cr, br, ar};
    doPush = iv && (exp_q.size() < DEPTH);
    doPop  = 1'b0;
    dst    = 0;
    if (exp_q.size() != 0) begin
      dst   = destOf(exp_q[0][WIDTH+1:WIDTH]);
      doPop = rdy[dst];
    end
    @(posedge clk);
    #1;
    if (doPop) begin
      void'(exp_q.pop_front());
      modelCnt[dst] = modelCnt[dst] + 1'b1;
    end
    if (doPush) exp_q.push_back({sel, d});
  endtask

  task automatic idleInputs();
    in_valid  = 1'b0;
    in_select = 2'd0;
    in_data   = '0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    c_ready   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_WIDTH-1:0] cHold;
    int                   readyBias;

    clearModel();
    idleInputs();
    reset = 1'b1;
    #2;
    checkVal("por_in_ready", in_ready, 1'b0);
    checkVal("por_busy", busy, 1'b0);
    checkVal("por_a_valid", a_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("por_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Routing, all destinations ready.
    step(1'b1, 2'd0, 16'h1111, 1'b1, 1'b1, 1'b1);
    checkVal("route_a1", a_data, 16'h1111);
    step(1'b1, 2'd1, 16'h2222, 1'b1, 1'b1, 1'b1);
    checkVal("route_b", b_data, 16'h2222);
    step(1'b1, 2'd2, 16'h3333, 1'b1, 1'b1, 1'b1);
    checkVal("route_c", c_data, 16'h3333);
    step(1'b1, 2'd3, 16'h4444, 1'b1, 1'b1, 1'b1);
    checkVal("route_a2", a_data, 16'h4444);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("route_cnt_a", a_count, 8'd2);
    checkVal("route_cnt_b", b_count, 8'd1);
    checkVal("route_cnt_c", c_count, 8'd1);

    // Backpressure to full.
    step(1'b1, 2'd1, 16'hAAAA, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'd1, 16'hBBBB, 1'b1, 1'b0, 1'b1);
    checkVal("full_in_ready", in_ready, 1'b0);
    checkVal("full_b_hold", b_data, 16'hAAAA);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("drain_b_second", b_data, 16'hBBBB);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("drain_in_ready", in_ready, 1'b1);
    checkVal("drain_busy", busy, 1'b0);

    // Head-of-line blocking.
    step(1'b1, 2'd0, 16'h0001, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'd2, 16'h0002, 1'b0, 1'b1, 1'b1);
    cHold = c_count;
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    checkVal("hol_c_valid", c_valid, 1'b0);
    checkVal("hol_c_count", c_count, cHold);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("hol_c_after", c_data, 16'h0002);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("hol_c_count_inc", c_count, cHold + 1'b1);

    // Pop at full with input held valid: push waits one cycle.
    step(1'b1, 2'd0, 16'h0A01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 16'h0A02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 16'h0C03, 1'b1, 1'b1, 1'b1);
    checkVal("cf_a_next", a_data, 16'h0A02);
    checkVal("cf_one_left", busy, 1'b1);
    step(1'b1, 2'd2, 16'h0C03, 1'b1, 1'b1, 1'b1);
    checkVal("cf_c_head", c_data, 16'h0C03);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Reset mid-cycle with two words buffered.
    step(1'b1, 2'd0, 16'hC0DE, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    idleInputs();
    #3;
    reset = 1'b1;
    #1;
    checkVal("rst_a_valid", a_valid, 1'b0);
    checkVal("rst_b_valid", b_valid, 1'b0);
    checkVal("rst_c_valid", c_valid, 1'b0);
    checkVal("rst_a_data", a_data, '0);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_in_ready", in_ready, 1'b0);
    checkVal("rst_a_count", a_count, '0);
    checkVal("rst_b_count", b_count, '0);
    checkVal("rst_c_count", c_count, '0);
    clearModel();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("rst_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Counter wrap on C, back-to-back at full rate.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd2, WIDTH'(i), 1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkVal("wrap_c_count", c_count, '0);
    checkVal("wrap_a_count", a_count, '0);
    checkVal("wrap_b_count", b_count, '0);

    // Random traffic with varying ready pressure.
    for (int i = 0; i < 3000; i++) begin
      readyBias = (i / 500) % 3;
      step($urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           WIDTH'($urandom),
           $urandom_range(0, 3) > readyBias,
           $urandom_range(0, 3) > readyBias,
           $urandom_range(0, 3) > readyBias);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    end
    checkVal("final_drained", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
